// File: rtl/ncpu32k_insn_buf.sv
// ncpu32k_insn_buf: in-order instruction fetch buffer between fetch/ITLB and decode.
// Holds 2^DEPTH_LOG2 entries {insn, pc, EITM, EIPF}. A pending interrupt is attached
// to the head entry. A flush empties the buffer but keeps any pending interrupt.
// Optional macro NCPU_IBUF_BYPASS_EN: an empty buffer forwards the incoming entry
// combinationally (zero-cycle latency). Without it, every entry passes through storage.
`ifndef NCPU_IW
`define NCPU_IW 32
`endif
`ifndef NCPU_AW
`define NCPU_AW 32
`endif

module ncpu32k_insn_buf #(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                ifu_valid,
   output logic                ifu_ready,
   input  logic [`NCPU_IW-1:0] ifu_insn,
   input  logic [`NCPU_AW-1:0] ifu_pc,
   input  logic                ifu_EITM,
   input  logic                ifu_EIPF,
   input  logic                irq_req,
   output logic                idu_valid,
   input  logic                idu_ready,
   output logic [`NCPU_IW-1:0] idu_insn,
   output logic [`NCPU_AW-1:0] idu_pc,
   output logic                idu_EITM,
   output logic                idu_EIPF,
   output logic                idu_EIRQ
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

   // Entry storage (no reset needed: contents are qualified by count)
   logic [`NCPU_IW-1:0] insn_q [DEPTH];
   logic [`NCPU_AW-1:0] pc_q   [DEPTH];
   logic                eitm_q [DEPTH];
   logic                eipf_q [DEPTH];

   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  irq_pend_q, irq_pend_d;

   logic empty, full;
   logic bypass;
   logic push, pop;
   logic stor_push, stor_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_FULL);

`ifdef NCPU_IBUF_BYPASS_EN
   // Empty buffer: present the incoming fetch directly to the decoder
   assign bypass = empty & ifu_valid & ~flush & ~rst;
`else
   assign bypass = 1'b0;
`endif

   // A full buffer refuses new entries even when the head pops in the same cycle
   assign ifu_ready = ~rst & ~flush & ~full;
   // Held low during reset so no handshake can complete while rst is high
   assign idu_valid = (~empty | bypass) & ~flush & ~rst;
   assign idu_EIRQ  = irq_pend_q & idu_valid;

   assign push = ifu_valid & ifu_ready;
   assign pop  = idu_valid & idu_ready;

   // A bypassed entry that is consumed immediately never touches storage;
   // a bypassed entry that stalls is written like any other push.
   assign stor_push = push & ~(bypass & pop);
   assign stor_pop  = pop & ~bypass;

   // Head-of-queue data, forced to zero whenever nothing is presented
   always_comb begin
      idu_insn = '0;
      idu_pc   = '0;
      idu_EITM = 1'b0;
      idu_EIPF = 1'b0;
      if (bypass) begin
         idu_insn = ifu_insn;
         idu_pc   = ifu_pc;
         idu_EITM = ifu_EITM;
         idu_EIPF = ifu_EIPF;
      end else if (idu_valid) begin
         idu_insn = insn_q[rd_ptr_q];
         idu_pc   = pc_q[rd_ptr_q];
         idu_EITM = eitm_q[rd_ptr_q];
         idu_EIPF = eipf_q[rd_ptr_q];
      end
   end

   // Next-state for pointers, occupancy and the pending interrupt
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (stor_push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (stor_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({stor_push, stor_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      // The interrupt leaves with exactly the entry that carried it
      irq_pend_d = (irq_pend_q | irq_req) & ~(pop & idu_EIRQ);
   end

   // Pointer/occupancy registers; flush empties the buffer like reset
   always_ff @(posedge clk) begin
      if (rst | flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Pending interrupt survives flush; only reset or delivery clears it
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_pend_q <= 1'b0;
      end else begin
         irq_pend_q <= irq_pend_d;
      end
   end

   // Entry write port
   always_ff @(posedge clk) begin
      if (stor_push) begin
         insn_q[wr_ptr_q] <= ifu_insn;
         pc_q[wr_ptr_q]   <= ifu_pc;
         eitm_q[wr_ptr_q] <= ifu_EITM;
         eipf_q[wr_ptr_q] <= ifu_EIPF;
      end
   end

endmodule

// File: tb/tb_ncpu32k_insn_buf.sv
// Self-checking bench for ncpu32k_insn_buf (DEPTH_LOG2=2, default build without bypass).
// Cycle table checks handshake/head outputs; a scoreboard checks delivered entry contents.
module tb_ncpu32k_insn_buf;

   logic        clk = 1'b0;
   logic        rst, flush, ifu_valid, ifu_ready;
   logic [31:0] ifu_insn, ifu_pc;
   logic        ifu_EITM, ifu_EIPF, irq_req;
   logic        idu_valid, idu_ready;
   logic [31:0] idu_insn, idu_pc;
   logic        idu_EITM, idu_EIPF, idu_EIRQ;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        rst, fl, iv;
      logic [31:0] insn, pc;
      logic        tm, pf, iq, ir;
      logic        e_ready, e_valid;
      logic [31:0] e_pc;
      logic        e_irq;
   } vec_t;

   typedef struct {
      logic [31:0] insn, pc;
      logic        tm, pf;
   } ent_t;

   vec_t tbl[$];
   ent_t sb_q[$];

   ncpu32k_insn_buf #(.DEPTH_LOG2(2)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .ifu_valid(ifu_valid), .ifu_ready(ifu_ready),
      .ifu_insn(ifu_insn), .ifu_pc(ifu_pc),
      .ifu_EITM(ifu_EITM), .ifu_EIPF(ifu_EIPF),
      .irq_req(irq_req),
      .idu_valid(idu_valid), .idu_ready(idu_ready),
      .idu_insn(idu_insn), .idu_pc(idu_pc),
      .idu_EITM(idu_EITM), .idu_EIPF(idu_EIPF), .idu_EIRQ(idu_EIRQ)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Row builder: insn 0 means "derive a unique word from the pc"
   function automatic vec_t v(logic r, logic fl, logic iv, logic [31:0] insn, logic [31:0] pc,
                              logic tm, logic pf, logic iq, logic ir,
                              logic er, logic ev, logic [31:0] epc, logic eq);
      vec_t t;
      t.rst = r; t.fl = fl; t.iv = iv;
      t.insn = (insn != 32'h0) ? insn : (32'hC0DE_0000 ^ pc);
      t.pc = pc; t.tm = tm; t.pf = pf; t.iq = iq; t.ir = ir;
      t.e_ready = er; t.e_valid = ev; t.e_pc = epc; t.e_irq = eq;
      return t;
   endfunction

   task automatic drive(input vec_t t);
      @(negedge clk);
      rst = t.rst; flush = t.fl; ifu_valid = t.iv;
      ifu_insn = t.insn; ifu_pc = t.pc; ifu_EITM = t.tm; ifu_EIPF = t.pf;
      irq_req = t.iq; idu_ready = t.ir;
      #1;
   endtask

   // Record handshakes that will complete at the coming edge
   task automatic score();
      ent_t e;
      if (ifu_valid && ifu_ready)
         sb_q.push_back('{ifu_insn, ifu_pc, ifu_EITM, ifu_EIPF});
      if (idu_valid && idu_ready) begin
         if (sb_q.size() == 0) begin
            chk("sb_underflow", 64'(idu_pc), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = sb_q.pop_front();
            chk($sformatf("sb_insn_pc%0h", e.pc), 64'(idu_insn), 64'(e.insn));
            chk($sformatf("sb_pc_pc%0h", e.pc), 64'(idu_pc), 64'(e.pc));
            chk($sformatf("sb_eitm_pc%0h", e.pc), 64'(idu_EITM), 64'(e.tm));
            chk($sformatf("sb_eipf_pc%0h", e.pc), 64'(idu_EIPF), 64'(e.pf));
         end
      end
      if (rst || flush) sb_q.delete();
   endtask

   initial begin
      //                r fl iv insn          pc      tm pf iq ir   rdy vld epc     irq
      tbl.push_back(v(1, 0, 0, 0,            32'h0,   0, 0, 0, 0,   0, 0, 32'h0,   0)); // reset
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 0, 0,   1, 0, 32'h0,   0));
      tbl.push_back(v(0, 0, 1, 32'h12345678, 32'h100, 0, 0, 0, 1,   1, 0, 32'h0,   0)); // single push
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 0, 1,   1, 1, 32'h100, 0));
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 0, 0,   1, 0, 32'h0,   0));
      tbl.push_back(v(0, 0, 1, 0,            32'h0,   0, 0, 0, 0,   1, 0, 32'h0,   0)); // fill to 4
      tbl.push_back(v(0, 0, 1, 0,            32'h4,   0, 0, 0, 0,   1, 1, 32'h0,   0));
      tbl.push_back(v(0, 0, 1, 0,            32'h8,   0, 0, 0, 0,   1, 1, 32'h0,   0));
      tbl.push_back(v(0, 0, 1, 0,            32'hC,   0, 0, 0, 0,   1, 1, 32'h0,   0));
      tbl.push_back(v(0, 0, 1, 0,            32'h10,  0, 0, 0, 0,   0, 1, 32'h0,   0)); // full stalls
      tbl.push_back(v(0, 0, 1, 0,            32'h10,  0, 0, 0, 1,   0, 1, 32'h0,   0)); // full + pop: no push
      tbl.push_back(v(0, 0, 1, 0,            32'h10,  0, 0, 0, 0,   1, 1, 32'h4,   0)); // push next cycle
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 0, 0,   0, 1, 32'h4,   0)); // full again
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 0, 1,   0, 1, 32'h4,   0)); // drain in order
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 0, 1,   1, 1, 32'h8,   0));
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 0, 1,   1, 1, 32'hC,   0));
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 0, 1,   1, 1, 32'h10,  0));
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 0, 0,   1, 0, 32'h0,   0));
      tbl.push_back(v(0, 0, 1, 0,            32'h200, 0, 1, 0, 0,   1, 0, 32'h0,   0)); // EIPF entry
      tbl.push_back(v(0, 0, 1, 0,            32'h204, 0, 0, 0, 1,   1, 1, 32'h200, 0));
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 0, 1,   1, 1, 32'h204, 0));
      tbl.push_back(v(0, 0, 1, 0,            32'h400, 0, 0, 0, 0,   1, 0, 32'h0,   0)); // fill 3, flush
      tbl.push_back(v(0, 0, 1, 0,            32'h404, 0, 0, 0, 0,   1, 1, 32'h400, 0));
      tbl.push_back(v(0, 0, 1, 0,            32'h408, 0, 0, 0, 0,   1, 1, 32'h400, 0));
      tbl.push_back(v(0, 1, 1, 0,            32'h40C, 0, 0, 0, 1,   0, 0, 32'h0,   0));
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 0, 1,   1, 0, 32'h0,   0));
      tbl.push_back(v(0, 0, 1, 0,            32'h500, 0, 0, 0, 0,   1, 0, 32'h0,   0));
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 0, 1,   1, 1, 32'h500, 0));
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 0, 0,   1, 0, 32'h0,   0));
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 1, 0,   1, 0, 32'h0,   0)); // irq pulse, empty
      tbl.push_back(v(0, 0, 1, 0,            32'h300, 1, 0, 0, 0,   1, 0, 32'h0,   0));
      tbl.push_back(v(0, 0, 1, 0,            32'h304, 0, 0, 0, 0,   1, 1, 32'h300, 1));
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 0, 1,   1, 1, 32'h300, 1));
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 0, 1,   1, 1, 32'h304, 0));
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 0, 0,   1, 0, 32'h0,   0));
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 1, 0,   1, 0, 32'h0,   0)); // irq then flush
      tbl.push_back(v(0, 1, 0, 0,            32'h0,   0, 0, 0, 0,   0, 0, 32'h0,   0));
      tbl.push_back(v(0, 0, 1, 0,            32'h600, 0, 0, 0, 0,   1, 0, 32'h0,   0));
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 0, 1,   1, 1, 32'h600, 1));
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 0, 0,   1, 0, 32'h0,   0));
      tbl.push_back(v(0, 0, 1, 0,            32'h800, 0, 0, 0, 0,   1, 0, 32'h0,   0)); // reset while busy
      tbl.push_back(v(0, 0, 1, 0,            32'h804, 0, 0, 1, 0,   1, 1, 32'h800, 0));
      tbl.push_back(v(1, 0, 0, 0,            32'h0,   0, 0, 0, 0,   0, 0, 32'h0,   0));
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 0, 0,   1, 0, 32'h0,   0));
      tbl.push_back(v(0, 0, 1, 0,            32'h900, 0, 0, 0, 0,   1, 0, 32'h0,   0));
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 0, 1,   1, 1, 32'h900, 0));
      tbl.push_back(v(0, 0, 0, 0,            32'h0,   0, 0, 0, 0,   1, 0, 32'h0,   0));

      rst = 1'b1; flush = 1'b0; ifu_valid = 1'b0; ifu_insn = '0; ifu_pc = '0;
      ifu_EITM = 1'b0; ifu_EIPF = 1'b0; irq_req = 1'b0; idu_ready = 1'b0;
      @(posedge clk);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         chk($sformatf("r%0d_ifu_ready", i), 64'(ifu_ready), 64'(tbl[i].e_ready));
         chk($sformatf("r%0d_idu_valid", i), 64'(idu_valid), 64'(tbl[i].e_valid));
         chk($sformatf("r%0d_idu_pc", i),    64'(idu_pc),    64'(tbl[i].e_pc));
         chk($sformatf("r%0d_idu_EIRQ", i),  64'(idu_EIRQ),  64'(tbl[i].e_irq));
         score();
      end

      // Streaming: one entry per cycle with both sides always ready
      for (int i = 0; i < 8; i++) begin
         drive(v(0, 0, 1, 0, 32'h700 + 32'(4 * i), 0, 0, 0, 1, 1, 1, 32'h0, 0));
         chk($sformatf("stream%0d_ifu_ready", i), 64'(ifu_ready), 64'd1);
         if (i > 0) chk($sformatf("stream%0d_idu_valid", i), 64'(idu_valid), 64'd1);
         score();
      end

      // Drain whatever is left, with a bounded wait
      begin
         int budget = 0;
         while (sb_q.size() != 0 && budget < 20) begin
            drive(v(0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 1, 0, 32'h0, 0));
            score();
            budget++;
         end
         chk("drain_timeout", 64'(sb_q.size()), 64'd0);
      end

      drive(v(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0, 0));
      chk("final_idu_valid", 64'(idu_valid), 64'd0);
      chk("final_idu_insn",  64'(idu_insn),  64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
